// File: rtl/imem_loader.sv
// Instruction memory loader: receives a framed image (length, payload, checksum)
// over a valid/ready byte stream, writes the payload into memory and holds the core until a clean image lands.
module imem_loader #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,      // asynchronous, active-low
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cpu_hold,
  output logic [1:0]        o_state
);

  // Stream handshake: a byte moves on a rising edge where i_in_valid and
  // o_in_ready are both high; o_in_ready is registered and never depends on i_in_valid.
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CSUM} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_cpu_hold;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]   r_sum;
  logic [DATA_W:0]     r_remaining;

  logic                w_xfer;
  logic [DATA_W-1:0]   w_sum_next;

  assign w_xfer     = i_in_valid & r_in_ready;
  assign w_sum_next = r_sum + i_in_data;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= START_ADDR;
      r_mem_wdata <= '0;
      r_ptr       <= START_ADDR;
      r_sum       <= '0;
      r_remaining <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LEN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_sum      <= '0;
            r_ptr      <= START_ADDR;
          end
        end
        S_LEN: begin
          // A zero length byte stands for a full 2^DATA_W payload.
          if (w_xfer) begin
            r_remaining <= {(i_in_data == '0), i_in_data};
            r_sum       <= i_in_data;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= i_in_data;
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_sum       <= w_sum_next;
            r_remaining <= r_remaining - (DATA_W+1)'(1);
            if (r_remaining == (DATA_W+1)'(1)) r_state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_error    <= (w_sum_next != '0);
            r_cpu_hold <= (w_sum_next != '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_state     = r_state;

endmodule
